// File: rtl/video_pkg.sv
// Shared raster timing constants, FSM encoding and helpers for the video output path.
package video_pkg;

    // Default 640x480@60 timing set (25.2 MHz pixel clock)
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_SETTLE   = 1024;

    // Raster generator control states
    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StSettle   = 2'd1,
        StRun      = 2'd2
    } vt_state_e;

    // Total period of one axis: active + front porch + sync + back porch
    function automatic int unsigned calc_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for single-bit or multi-bit level signals.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input; reset clears both stages
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-domain raster timing generator: qualifies PLL lock, then emits sync/de/coordinates.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned SETTLE   = VGA_SETTLE,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_pll_lock,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_de,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_frame_start,
    output logic           o_running
);

    localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned S_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_BEG   = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_BEG   = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [S_W-1:0] S_LAST   = S_W'(SETTLE - 1);

    logic           w_lock_s;
    vt_state_e      r_state;
    vt_state_e      w_state_next;
    logic [S_W-1:0] r_settle_cnt;
    logic [S_W-1:0] w_settle_next;
    logic [X_W-1:0] r_h_cnt;
    logic [Y_W-1:0] r_v_cnt;
    logic           w_de;
    logic           w_hs_act;
    logic           w_vs_act;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_lock),
        .o_q     (w_lock_s)
    );

    // FSM state and settle counter registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StWaitLock;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
        end
    end

    // Lock qualification: lock must hold SETTLE cycles; any loss drops back immediately
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = '0;
        unique case (r_state)
            StWaitLock: begin
                if (w_lock_s) w_state_next = StSettle;
            end
            StSettle: begin
                if (!w_lock_s) begin
                    w_state_next = StWaitLock;
                end else if (r_settle_cnt == S_LAST) begin
                    w_state_next = StRun;
                end else begin
                    w_settle_next = r_settle_cnt + 1'b1;
                end
            end
            StRun: begin
                if (!w_lock_s) w_state_next = StWaitLock;
            end
            default: w_state_next = StWaitLock;
        endcase
    end

    // Raster counters: run only in StRun, otherwise parked at the origin
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || (r_state != StRun)) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Region decode of the current counter position
    always_comb begin
        w_de     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_hs_act = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
        w_vs_act = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
    end

    // Registered outputs, one cycle behind the counters
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || (r_state != StRun)) begin
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            o_running     <= 1'b0;
        end else begin
            o_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            o_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            o_de          <= w_de;
            o_x           <= w_de ? r_h_cnt : '0;
            o_y           <= w_de ? r_v_cnt : '0;
            o_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            o_running     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: cycle scoreboard on a small-timing instance plus a default-size instance.
module tb_video_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int ST = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic       running;
        logic       fs;
        logic       de;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small-timing instance
    logic       rst_n;
    logic       pll_lock;
    logic       s_hsync;
    logic       s_vsync;
    logic       s_de;
    logic [9:0] s_x;
    logic [9:0] s_y;
    logic       s_fs;
    logic       s_running;
    obs_t       got_s;

    // Default 640x480 instance
    logic       rst_b;
    logic       lock_b;
    logic       b_hsync;
    logic       b_vsync;
    logic       b_de;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic       b_fs;
    logic       b_running;

    video_timing_gen #(
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB),
        .HS_POL   (1'b0),
        .VS_POL   (1'b0),
        .SETTLE   (ST),
        .X_W      (10),
        .Y_W      (10)
    ) dut_s (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pll_lock    (pll_lock),
        .o_hsync       (s_hsync),
        .o_vsync       (s_vsync),
        .o_de          (s_de),
        .o_x           (s_x),
        .o_y           (s_y),
        .o_frame_start (s_fs),
        .o_running     (s_running)
    );

    video_timing_gen #(
        .X_W (10),
        .Y_W (10)
    ) dut_b (
        .i_clk         (clk),
        .i_rst_n       (rst_b),
        .i_pll_lock    (lock_b),
        .o_hsync       (b_hsync),
        .o_vsync       (b_vsync),
        .o_de          (b_de),
        .o_x           (b_x),
        .o_y           (b_y),
        .o_frame_start (b_fs),
        .o_running     (b_running)
    );

    assign got_s = '{running: s_running, fs: s_fs, de: s_de, hs: s_hsync, vs: s_vsync,
                     x: s_x, y: s_y};

    int   n_chk  = 0;
    int   n_pass = 0;
    obs_t exp_q[$];

    // Reference model state: lock pipeline, controller, cycles spent in run
    int m_s1  = 0;
    int m_s2  = 0;
    int m_st  = 0;
    int m_cnt = 0;
    int m_t   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Expected outputs after one edge, from inputs sampled at that edge
    task automatic model_step();
        obs_t e;
        int   h;
        int   v;
        e = reset_obs();
        if (rst_n && m_st == 2) begin
            h         = m_t % HT;
            v         = (m_t / HT) % VT;
            e.running = 1'b1;
            e.de      = (h < HA) && (v < VA);
            e.fs      = (h == 0) && (v == 0);
            e.hs      = !((h >= HA + HF) && (h < HA + HF + HS));
            e.vs      = !((v >= VA + VF) && (v < VA + VF + VS));
            e.x       = e.de ? 10'(h) : 10'd0;
            e.y       = e.de ? 10'(v) : 10'd0;
        end
        exp_q.push_back(e);
        if (!rst_n) begin
            m_s1  = 0;
            m_s2  = 0;
            m_st  = 0;
            m_cnt = 0;
            m_t   = 0;
        end else begin
            case (m_st)
                0: if (m_s2 != 0) begin m_st = 1; m_cnt = 0; end
                1: begin
                    if (m_s2 == 0) m_st = 0;
                    else if (m_cnt == ST - 1) begin m_st = 2; m_t = 0; end
                    else m_cnt++;
                end
                default: begin
                    if (m_s2 == 0) m_st = 0;
                    else m_t++;
                end
            endcase
            m_s2 = m_s1;
            m_s1 = int'(pll_lock);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Scoreboard: compare each cycle's outputs on the falling edge
    initial forever begin
        obs_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cyc", 32'(got_s), 32'(e));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run_s(input int budget, output int n);
        n = 0;
        do begin tick(); n++; end while (!s_running && n < budget);
    endtask

    task automatic seek_t(input int target);
        int k;
        k = 0;
        while (m_t != target && k < 300) begin tick(); k++; end
        check("seek", 32'(m_t), 32'(target));
    endtask

    initial begin
        int n;
        int de_cnt;
        int hs_cnt;
        int vs_cnt;
        int fs0;
        int fs1;
        int last_x;
        obs_t first_px;

        rst_n    = 1'b0;
        pll_lock = 1'b1;
        rst_b    = 1'b0;
        lock_b   = 1'b0;
        first_px = '{running: 1'b1, fs: 1'b1, de: 1'b1, hs: 1'b1, vs: 1'b1, x: 10'd0, y: 10'd0};

        // Reset held with lock high, then release
        repeat (4) tick();
        check("rst_vals", 32'(got_s), 32'(reset_obs()));
        rst_n = 1'b1;
        wait_run_s(40, n);
        check("rise", 32'(n), 32'd8);
        check("first_px", 32'(got_s), 32'(first_px));

        // Two steady frames
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs0 = -1; fs1 = -1;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (s_fs) begin
                if (fs0 < 0) fs0 = i;
                else fs1 = i;
            end
            de_cnt += int'(s_de);
            hs_cnt += int'(!s_hsync);
            vs_cnt += int'(!s_vsync);
            tick();
        end
        check("de_cnt", 32'(de_cnt), 32'(2 * HA * VA));
        check("hs_cnt", 32'(hs_cnt), 32'(2 * HS * VT));
        check("vs_cnt", 32'(vs_cnt), 32'(2 * VS * HT));
        check("fs_period", 32'(fs1 - fs0), 32'(HT * VT));

        // One-cycle lock glitch while settling
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_run_s(40, n);
        check("glitch_rise", 32'(n + 4), 32'd12);

        // Lock loss mid-frame at (5,2), then relock
        seek_t(2 * HT + 5);
        pll_lock = 1'b0;
        wait_run_s(1, n);
        n = 1;
        while (s_running && n < 10) begin tick(); n++; end
        check("drop_lat", 32'(n), 32'd4);
        check("drop_vals", 32'(got_s), 32'(reset_obs()));
        pll_lock = 1'b1;
        wait_run_s(40, n);
        check("relock_rise", 32'(n), 32'd8);
        check("relock_px", 32'(got_s), 32'(first_px));

        // One-cycle reset at (13,6) with both wraps pending
        seek_t(6 * HT + 13);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid", 32'(got_s), 32'(reset_obs()));
        wait_run_s(40, n);
        check("rst_rise", 32'(n), 32'd8);

        // Default 640x480 instance: startup and first full line
        lock_b = 1'b1;
        repeat (2) tick();
        rst_b = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!b_running && n < 1100);
        check("b_rise", 32'(n), 32'd1028);
        check("b_first", 32'({b_fs, b_de, b_x, b_y}), 32'({1'b1, 1'b1, 20'd0}));
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; last_x = -1;
        for (int i = 0; i < 800; i++) begin
            de_cnt += int'(b_de);
            hs_cnt += int'(!b_hsync);
            vs_cnt += int'(!b_vsync);
            if (b_de) last_x = int'(b_x);
            tick();
        end
        check("b_de_line", 32'(de_cnt), 32'd640);
        check("b_hs_width", 32'(hs_cnt), 32'd96);
        check("b_vs_idle", 32'(vs_cnt), 32'd0);
        check("b_last_x", 32'(last_x), 32'd639);
        check("b_line1", 32'({b_de, b_x, b_y}), 32'({1'b1, 10'd0, 10'd1}));

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
